// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
// Forwarding and load-use hazard unit for the pipelined CPU. It tracks the
// destination tags of the instruction in EX and of the post-EX pipeline
// registers, compares the ID operands against them, registers a bypass select
// per operand for the instruction entering EX, and raises a combinational
// load-use stall. Stall cycles are counted with a saturating 16-bit counter.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   freeze_i       whole pipeline held: tags, selects and counter hold
//   flush_i        kill the ID instruction (bubble into EX, no stall)
//   id_valid_i     ID holds a valid instruction
//   id_regwrite_i  ID instruction writes id_rd_i
//   id_memread_i   ID instruction is a load
//   id_rd_i        ID destination register
//   id_rs_i        ID source registers, operand j at [j*AW +: AW]
//   id_rs_used_i   operand j is actually read
//   stall_o        load-use stall (hold IF/ID, bubble into EX)
//   fwd_sel_o      per-operand select for the instruction in EX:
//                  0 = register file, k = pipeline register k
//   stall_count_o  saturating stall-cycle count
module fwd_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int AW         = 5,
  parameter int LOAD_STAGE = 2,
  parameter int SW         = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    freeze_i,
  input  logic                    flush_i,
  input  logic                    id_valid_i,
  input  logic                    id_regwrite_i,
  input  logic                    id_memread_i,
  input  logic [AW-1:0]           id_rd_i,
  input  logic [NUM_SRC*AW-1:0]   id_rs_i,
  input  logic [NUM_SRC-1:0]      id_rs_used_i,
  output logic                    stall_o,
  output logic [NUM_SRC*SW-1:0]   fwd_sel_o,
  output logic [15:0]             stall_count_o
);

  // Saturating increment for the stall counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Tag entries t[0..DEPTH-1]. The oldest entry t[DEPTH] is not stored: it
  // is never a forwarding source because the register file writes through
  // the WB result, so it could never influence any output.
  logic [DEPTH-1:0]      tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0]      tag_wr_q;
  logic [DEPTH-1:0]      tag_ld_q;
  logic [AW-1:0]         tag_rd_q [DEPTH];

  logic [NUM_SRC*SW-1:0] sel_next;
  logic [NUM_SRC*SW-1:0] fwd_sel_q, fwd_sel_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [NUM_SRC-1:0]    hazard;
  logic                  bubble;

  // ID-stage compare: walk from the oldest forwarding tag to the youngest so
  // that the youngest match overwrites older ones. The hazard flag follows
  // the same overwrite, so an older load behind a younger ALU producer does
  // not stall.
  always_comb begin
    sel_next = '0;
    hazard   = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int m = DEPTH - 1; m >= 0; m--) begin
        if (tag_vld_q[m] && tag_wr_q[m] && (tag_rd_q[m] != '0) &&
            (tag_rd_q[m] == id_rs_i[j*AW +: AW]) &&
            id_valid_i && id_rs_used_i[j]) begin
          sel_next[j*SW +: SW] = SW'(m + 1);
          hazard[j]            = tag_ld_q[m] && ((m + 1) < LOAD_STAGE);
        end
      end
    end
  end

  assign stall_o = (|hazard) && !flush_i && !freeze_i;
  // A flushed or stalled cycle sends an invalid tag and a zero select into EX.
  assign bubble  = flush_i || stall_o;

  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = id_valid_i && !bubble;
    for (int k = 1; k < DEPTH; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
    end
    fwd_sel_d = bubble ? '0 : sel_next;
    cnt_d     = stall_o ? sat_inc(cnt_q) : cnt_q;
  end

  // ID -> EX boundary: control state with reset, held while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      fwd_sel_q <= '0;
      cnt_q     <= '0;
    end else if (!freeze_i) begin
      tag_vld_q <= tag_vld_d;
      fwd_sel_q <= fwd_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  // Tag payload shifts with the valid bits; contents of invalid entries are
  // don't-care, so the payload carries no reset.
  always_ff @(posedge clk) begin
    if (!freeze_i) begin
      tag_wr_q[0] <= id_regwrite_i;
      tag_ld_q[0] <= id_memread_i;
      tag_rd_q[0] <= id_rd_i;
      for (int k = 1; k < DEPTH; k++) begin
        tag_wr_q[k] <= tag_wr_q[k-1];
        tag_ld_q[k] <= tag_ld_q[k-1];
        tag_rd_q[k] <= tag_rd_q[k-1];
      end
    end
  end

  assign fwd_sel_o     = fwd_sel_q;
  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard. Three instances share clock and reset:
//   0: defaults (NUM_SRC=2, DEPTH=2, LOAD_STAGE=2)
//   1: NUM_SRC=3, DEPTH=3, LOAD_STAGE=3
//   2: NUM_SRC=1, DEPTH=15, LOAD_STAGE=15 (long load-use chains for counter
//      saturation)
// The reference model keeps a log of what entered EX each cycle and searches
// it back from the newest entry for the youngest producer of each operand.
module tb_fwd_scoreboard;

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } instr_t;

  typedef struct packed {
    logic            valid;
    logic            wr;
    logic            ld;
    logic            frz;
    logic            fl;
    logic [4:0]      rd;
    logic [2:0][4:0] rs;
    logic [2:0]      used;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stim_t st [3];

  logic        a_stall, b_stall, c_stall;
  logic [3:0]  a_fwd;
  logic [5:0]  b_fwd;
  logic [3:0]  c_fwd;
  logic [15:0] a_cnt, b_cnt, c_cnt;

  fwd_scoreboard u_a (
    .clk(clk), .rst_n(rst_n), .freeze_i(st[0].frz), .flush_i(st[0].fl),
    .id_valid_i(st[0].valid), .id_regwrite_i(st[0].wr), .id_memread_i(st[0].ld),
    .id_rd_i(st[0].rd), .id_rs_i(st[0].rs[1:0]), .id_rs_used_i(st[0].used[1:0]),
    .stall_o(a_stall), .fwd_sel_o(a_fwd), .stall_count_o(a_cnt)
  );

  fwd_scoreboard #(.NUM_SRC(3), .DEPTH(3), .AW(5), .LOAD_STAGE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .freeze_i(st[1].frz), .flush_i(st[1].fl),
    .id_valid_i(st[1].valid), .id_regwrite_i(st[1].wr), .id_memread_i(st[1].ld),
    .id_rd_i(st[1].rd), .id_rs_i(st[1].rs), .id_rs_used_i(st[1].used),
    .stall_o(b_stall), .fwd_sel_o(b_fwd), .stall_count_o(b_cnt)
  );

  fwd_scoreboard #(.NUM_SRC(1), .DEPTH(15), .AW(5), .LOAD_STAGE(15)) u_c (
    .clk(clk), .rst_n(rst_n), .freeze_i(st[2].frz), .flush_i(st[2].fl),
    .id_valid_i(st[2].valid), .id_regwrite_i(st[2].wr), .id_memread_i(st[2].ld),
    .id_rd_i(st[2].rd), .id_rs_i(st[2].rs[0]), .id_rs_used_i(st[2].used[0]),
    .stall_o(c_stall), .fwd_sel_o(c_fwd), .stall_count_o(c_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  instr_t          hist [3][32];
  int              wp [3];
  int              nent [3];
  logic [2:0][3:0] psel [3];
  bit              phz [3];
  logic [2:0][3:0] exp_sel [3];
  int              exp_cnt [3];
  int              raw_stalls [3];
  bit              stall_seen [3];

  function automatic int p_nsrc(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 1;
  endfunction
  function automatic int p_depth(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 15;
  endfunction
  function automatic int p_lst(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 15;
  endfunction
  function automatic int p_sw(input int i);
    return (i == 2) ? 4 : 2;
  endfunction

  function automatic int get_stall(input int i);
    return (i == 0) ? int'(a_stall) : (i == 1) ? int'(b_stall) : int'(c_stall);
  endfunction
  function automatic int get_fwd(input int i);
    return (i == 0) ? int'(a_fwd) : (i == 1) ? int'(b_fwd) : int'(c_fwd);
  endfunction
  function automatic int get_cnt(input int i);
    return (i == 0) ? int'(a_cnt) : (i == 1) ? int'(b_cnt) : int'(c_cnt);
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0; nent[i] = 0; exp_sel[i] = '0; exp_cnt[i] = 0; raw_stalls[i] = 0;
    end
  endfunction

  // Youngest producer search over the last DEPTH entries of the EX log.
  function automatic void model_eval(input int i);
    stim_t  s;
    instr_t e;
    s = st[i];
    psel[i] = '0;
    phz[i]  = 1'b0;
    for (int j = 0; j < p_nsrc(i); j++) begin
      bit found;
      found = 1'b0;
      for (int m = 0; m < p_depth(i) && m < nent[i]; m++) begin
        e = hist[i][(wp[i] - 1 - m) & 31];
        if (!found && e.vld && e.wr && e.rd != 5'd0 && e.rd == s.rs[j] &&
            s.valid && s.used[j]) begin
          found = 1'b1;
          psel[i][j] = 4'(m + 1);
          if (e.ld && (m + 1) < p_lst(i)) phz[i] = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_clock(input int i);
    stim_t  s;
    instr_t ent;
    bit     stl;
    s = st[i];
    if (!s.frz) begin
      stl = phz[i] && !s.fl;
      ent = (s.fl || stl) ? instr_t'(0) : instr_t'({s.valid, s.wr, s.ld, s.rd});
      hist[i][wp[i] & 31] = ent;
      wp[i]++;
      if (nent[i] < 32) nent[i]++;
      exp_sel[i] = (s.fl || stl) ? '0 : psel[i];
      if (stl) begin
        raw_stalls[i]++;
        if (exp_cnt[i] < 65535) exp_cnt[i]++;
      end
    end
  endfunction

  function automatic int exp_bus(input int i);
    int r;
    r = 0;
    for (int j = 0; j < p_nsrc(i); j++) r |= int'(exp_sel[i][j]) << (j * p_sw(i));
    return r;
  endfunction

  // One cycle: inputs are already driven just after a rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      model_eval(i);
      stall_seen[i] = (get_stall(i) != 0);
      chk($sformatf("stall[%0d]", i), get_stall(i),
          int'(phz[i] && !st[i].fl && !st[i].frz));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_clock(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fwd_sel[%0d]", i), get_fwd(i), exp_bus(i));
      chk($sformatf("count[%0d]", i), get_cnt(i), exp_cnt[i]);
    end
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s.valid = ($urandom_range(0, 9) != 0);
    s.wr    = ($urandom_range(0, 3) != 0);
    s.ld    = ($urandom_range(0, 2) == 0);
    s.frz   = ($urandom_range(0, 9) == 0);
    s.fl    = ($urandom_range(0, 11) == 0);
    s.rd    = 5'($urandom_range(0, 5));
    for (int j = 0; j < 3; j++) s.rs[j] = 5'($urandom_range(0, 5));
    s.used  = 3'($urandom_range(0, 7));
    return s;
  endfunction

  function automatic stim_t mk(input bit v, input bit wr, input bit ld, input int rd,
                               input int rs0, input int rs1, input bit u0, input bit u1,
                               input bit frz, input bit fl);
    stim_t s;
    s = '0;
    s.valid = v; s.wr = wr; s.ld = ld; s.rd = 5'(rd);
    s.rs[0] = 5'(rs0); s.rs[1] = 5'(rs1);
    s.used[0] = u0; s.used[1] = u1;
    s.frz = frz; s.fl = fl;
    return s;
  endfunction

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_stall[%0d]", tag, i), get_stall(i), 0);
      chk($sformatf("%s_fwd[%0d]", tag, i), get_fwd(i), 0);
      chk($sformatf("%s_cnt[%0d]", tag, i), get_cnt(i), 0);
    end
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 3; i++) st[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // ALU chain, back to back
    st[0] = mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 0); step();
    st[0] = mk(1, 1, 0, 6, 3, 3, 1, 1, 0, 0); step();
    chk("alu_chain", int'(a_fwd), 5);
    // ALU chain with one independent instruction between
    st[0] = mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 0); step();
    st[0] = mk(1, 1, 0, 7, 1, 2, 1, 1, 0, 0); step();
    st[0] = mk(1, 1, 0, 8, 3, 3, 1, 1, 0, 0); step();
    chk("alu_gap", int'(a_fwd), 10);
    // Youngest producer wins
    st[0] = mk(1, 1, 0, 4, 0, 0, 0, 0, 0, 0); step();
    st[0] = mk(1, 1, 0, 4, 0, 0, 0, 0, 0, 0); step();
    st[0] = mk(1, 1, 0, 9, 4, 0, 1, 0, 0, 0); step();
    chk("priority", int'(a_fwd), 1);
    // r0 never forwards
    st[0] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    st[0] = mk(1, 1, 0, 9, 0, 0, 1, 1, 0, 0); step();
    chk("r0_sel", int'(a_fwd), 0);

    // Load-use
    st[0] = '0; step(); step();
    c0 = int'(a_cnt);
    st[0] = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0); step();
    st[0] = mk(1, 1, 0, 10, 5, 1, 1, 1, 0, 0); step();
    chk("lu_stall", int'(stall_seen[0]), 1);
    chk("lu_bubble_sel", int'(a_fwd), 0);
    step();
    chk("lu_stall_clear", int'(stall_seen[0]), 0);
    chk("lu_sel", int'(a_fwd), 2);
    chk("lu_cnt", int'(a_cnt), c0 + 1);
    // Unused operand does not stall
    st[0] = '0; step(); step();
    st[0] = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0); step();
    st[0] = mk(1, 1, 0, 10, 5, 1, 0, 1, 0, 0); step();
    chk("lu_unused", int'(stall_seen[0]), 0);
    // Flush beats hazard
    st[0] = '0; step(); step();
    c0 = int'(a_cnt);
    st[0] = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0); step();
    st[0] = mk(1, 1, 0, 10, 5, 0, 1, 0, 0, 1); step();
    chk("flush_stall", int'(stall_seen[0]), 0);
    chk("flush_sel", int'(a_fwd), 0);
    chk("flush_cnt", int'(a_cnt), c0);
    // Freeze during a hazard
    st[0] = '0; step(); step();
    c0 = int'(a_cnt);
    st[0] = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0); step();
    st[0] = mk(1, 1, 0, 10, 5, 0, 1, 0, 1, 0);
    repeat (3) begin
      step();
      chk("frz_stall", int'(stall_seen[0]), 0);
      chk("frz_sel", int'(a_fwd), 0);
      chk("frz_cnt", int'(a_cnt), c0);
    end
    st[0] = mk(1, 1, 0, 10, 5, 0, 1, 0, 0, 0); step();
    chk("frz_release_stall", int'(stall_seen[0]), 1);
    chk("frz_release_cnt", int'(a_cnt), c0 + 1);
    step();
    chk("frz_release_sel", int'(a_fwd), 2);
    st[0] = '0;

    // Deeper configuration: two stall cycles, then select 3
    c0 = int'(b_cnt);
    st[1] = '0; st[1].valid = 1; st[1].wr = 1; st[1].ld = 1; st[1].rd = 5; step();
    st[1] = '0; st[1].valid = 1; st[1].wr = 1; st[1].rd = 11;
    st[1].rs[0] = 5; st[1].used[0] = 1;
    step(); chk("b_stall1", int'(stall_seen[1]), 1);
    step(); chk("b_stall2", int'(stall_seen[1]), 1);
    step(); chk("b_stall3", int'(stall_seen[1]), 0);
    chk("b_sel", int'(b_fwd), 3);
    chk("b_cnt", int'(b_cnt), c0 + 2);

    // Random traffic on all instances
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) st[i] = rnd_stim();
      step();
    end

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async_reset");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    for (int i = 0; i < 3; i++) st[i] = rnd_stim();
    rst_n = 1'b1;
    step();

    // Saturation: instance 2 sees a self-dependent load every cycle
    st[2] = '0; st[2].valid = 1; st[2].wr = 1; st[2].ld = 1; st[2].rd = 5;
    st[2].rs[0] = 5; st[2].used[0] = 1;
    for (int n = 0; n < 75000 && raw_stalls[2] < 65540; n++) begin
      st[0] = rnd_stim();
      st[1] = rnd_stim();
      step();
    end
    chk("c_cnt_sat", int'(c_cnt), 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipelined CPU. It keeps its own shift register of in-flight destination tags for the EX stage and the D pipeline registers after EX. Each cycle it compares the operands of the instruction in ID against those tags. It produces a registered per-operand bypass select for the instruction entering EX, and a combinational load-use stall. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- `NUM_SRC`, default 2: number of source operands per instruction.
- `DEPTH`, default 2: number of post-EX pipeline registers that can forward (1 = EX/MEM, 2 = MEM/WB, …).
- `AW`, default 5: register address width.
- `LOAD_STAGE`, default 2: first pipeline register index at which load data can be forwarded (1 ≤ `LOAD_STAGE` ≤ `DEPTH`).
- `SW`, derived as clog2(`DEPTH`+1): width of one select field.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `freeze_i` in 1: whole pipeline held this cycle (e.g. cache miss).
- `flush_i` in 1: kill the ID instruction this cycle.
- `id_valid_i` in 1: ID holds a valid instruction.
- `id_regwrite_i` in 1: ID instruction writes `id_rd_i`.
- `id_memread_i` in 1: ID instruction is a load.
- `id_rd_i` in `AW`: ID destination register.
- `id_rs_i` in `NUM_SRC`*`AW`: ID source registers; operand j occupies bits [j*AW +: AW].
- `id_rs_used_i` in `NUM_SRC`: operand j is actually read.
- `stall_o` out 1: load-use stall. Holds IF/ID and inserts a bubble into EX.
- `fwd_sel_o` out `NUM_SRC`*`SW`: registered select per operand for the instruction now in EX. 0 = register file, k = pipeline register k.
- `stall_count_o` out 16: saturating count of stall cycles.

## Operation
- Tag array: entries t[0..DEPTH], each {valid, wr, load, rd}. t[0] is the instruction in EX; t[k] is the instruction in pipeline register k.
- A tag matches operand j if all of the following hold:
  - the tag's valid and wr bits are set;
  - the tag's rd ≠ 0 and rd == rs[j];
  - id_valid_i and id_rs_used_i[j] are set.
- Register 0 never matches.
- Operand j's candidate is the youngest matching tag t[m] over m = 0..DEPTH-1 (lowest m wins).
  - No match: next select = 0.
  - Match: next select = m+1, since that producer sits in register m+1 when the consumer reaches EX.
  - t[DEPTH] is never a source. The register file is write-through for the WB write.
- Load-use hazard for operand j: the youngest match is a load and m+1 < `LOAD_STAGE`.
  - stall_o = OR of the hazards across all operands, gated by !flush_i && !freeze_i.
  - An older load behind a younger non-load match does not stall.
- Cycle update, in priority order:
  - freeze: tags, fwd_sel_o and counter all hold.
  - flush: shift tags; t[0] ← invalid; fwd_sel_o ← 0.
  - stall: shift tags; t[0] ← invalid (bubble); fwd_sel_o ← 0; counter +1, saturating at 16'hFFFF.
  - normal: shift tags; t[0] ← {id_valid_i, id_regwrite_i, id_memread_i, id_rd_i}; fwd_sel_o ← the next selects.
- Shift means t[k+1] ← t[k] for k = 0..DEPTH-1; the old t[DEPTH] is dropped.
- Bits of an unused operand's select are 0.

## Timing
- Reset (async, rst_n = 0):
  - all tags invalid;
  - fwd_sel_o = 0;
  - stall_count_o = 0;
  - stall_o = 0, since no tag is valid.
- stall_o is combinational from ID inputs and tags, with zero latency. It must settle before the IF/ID enable of the same cycle.
- fwd_sel_o has one-cycle latency: it is computed in ID and registered, and valid for the whole EX cycle of that instruction.
- Load followed immediately by a dependent instruction, with defaults:
  - stall_o is asserted for exactly 1 cycle;
  - the dependent instruction then enters EX with select 2 (MEM/WB).
- With `LOAD_STAGE` = L, a back-to-back load-use stalls for L-1 cycles.
- Stall re-evaluates every cycle. The bubble advances, so the hazard clears without extra logic.
- Freeze during a stall: stall_o is forced low and the counter does not increment. The hazard re-asserts when freeze drops.
- Flush and hazard in the same cycle: flush wins; no stall and no count.
- Reset mid-operation discards all in-flight tags. The first instruction after reset always selects 0.

## Test plan
- Reset: hold rst_n = 0 mid-stream with valid tags. Required: fwd_sel_o = 0, stall_o = 0 and stall_count_o = 0 immediately (asynchronously), and after release.
- ALU chain: `add r3` then `sub` using rs0 = r3, rs1 = r3. Required: the sub's EX-cycle fwd_sel_o = {2'd1, 2'd1}. With one independent instruction between them: {2'd2, 2'd2}.
- Priority: `add r4`, `add r4`, then a consumer of r4. Required: select 1, not 2. A consumer of r0 after `add r0`: select 0.
- Load-use: `lw r5` then `add` using rs0 = r5. Required:
  - stall_o = 1 for one cycle, then the add gets select 2;
  - stall_count_o = 1;
  - with id_rs_used_i[0] = 0: no stall.
- Flush and freeze:
  - load-use plus flush_i in the same cycle: stall_o = 0, counter unchanged, next fwd_sel_o = 0;
  - freeze_i held 3 cycles during a hazard: tags and fwd_sel_o stable, counter unchanged.
- Parameters: `NUM_SRC` = 3, `DEPTH` = 3, `LOAD_STAGE` = 3 (SW = 2).
  - Load then dependent: 2 stall cycles, then select 3.
  - Counter saturation: preload by 65540 stalled cycles. Required: stall_count_o = 16'hFFFF.
